// File: rtl/regfile_pkg.sv
// Shared constants and types for the decode-stage register file.
// Latency: n/a (declarations only). Backpressure: n/a.
// Contents: DATA_WIDTH/ADDR_WIDTH defaults, reg_data_t/reg_addr_t, REG_ZERO index.
package regfile_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 1 << ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0] reg_data_t;
    typedef logic [ADDR_WIDTH-1:0] reg_addr_t;

    // Index of the hardwired-zero register.
    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/register_file_if.sv
// Bundle of the register file's read/write bus (addresses, write data/enable, read data).
// Latency: reads combinational, writes take effect at the next rising Clk edge.
// Backpressure: none; the register file accepts a write every cycle.
// Modports: master = datapath side (drives indices/write), slave = register file side.
interface register_file_if #(
    parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) ();

    logic [ADDR_WIDTH-1:0] ReadRegister1;
    logic [ADDR_WIDTH-1:0] ReadRegister2;
    logic [ADDR_WIDTH-1:0] WriteRegister;
    logic [DATA_WIDTH-1:0] WriteData;
    logic                  RegWrite;
    logic [DATA_WIDTH-1:0] ReadData1;
    logic [DATA_WIDTH-1:0] ReadData2;

    modport master (
        output ReadRegister1,
        output ReadRegister2,
        output WriteRegister,
        output WriteData,
        output RegWrite,
        input  ReadData1,
        input  ReadData2
    );

    modport slave (
        input  ReadRegister1,
        input  ReadRegister2,
        input  WriteRegister,
        input  WriteData,
        input  RegWrite,
        output ReadData1,
        output ReadData2
    );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: zero-register check, optional write-through bypass, array select.
// Latency: zero cycles (pure combinational). Backpressure: none.
// Ports: readAddr -> readData from regArray; bypassEn/writeAddr/writeData feed the
// forwarding path, which only exists when REGFILE_BYPASS_EN is defined.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
    parameter int NUM_REGS   = regfile_pkg::NUM_REGS
) (
    input  logic [ADDR_WIDTH-1:0]                readAddr,
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regArray,
    input  logic                                 bypassEn,
    input  logic [ADDR_WIDTH-1:0]                writeAddr,
    input  logic [DATA_WIDTH-1:0]                writeData,
    output logic [DATA_WIDTH-1:0]                readData
);

`ifdef REGFILE_BYPASS_EN
    // Forward the in-flight write so the same cycle sees the new value.
    // writeAddr != 0 is implied because readAddr is already known nonzero.
    always_comb begin
        readData = '0;
        if (readAddr != REG_ZERO) begin
            if (bypassEn && (readAddr == writeAddr)) begin
                readData = writeData;
            end else begin
                readData = regArray[readAddr];
            end
        end
    end
`else
    // Forwarding inputs are kept on the port list so both builds share one
    // instantiation; they are simply folded away here.
    logic unusedBypass;
    assign unusedBypass = bypassEn ^ (^writeAddr) ^ (^writeData);

    always_comb begin
        readData = '0;
        if (readAddr != REG_ZERO) begin
            readData = regArray[readAddr];
        end
    end
`endif

endmodule

// File: rtl/register_file.sv
// 32x32 decode-stage register file: two combinational read ports, one clocked write port.
// Latency: read 0 cycles; write visible right after the rising Clk edge (same cycle with REGFILE_BYPASS_EN).
// Backpressure: none; a write can be accepted every cycle, reset clears all entries asynchronously.
// Ports: Clk, Reset (async active-high), bus (register_file_if.slave). Optional macro: REGFILE_BYPASS_EN.
module register_file
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
    parameter int NUM_REGS   = regfile_pkg::NUM_REGS   // must equal 2**ADDR_WIDTH
) (
    input  logic            Clk,
    input  logic            Reset,
    register_file_if.slave  bus
);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regArray;
    logic                                writeEn;

    // Reset gates the write path, and therefore the bypass path too.
    assign writeEn = bus.RegWrite && !Reset;

    // Entry 0 is cleared by reset and never written, so it stays zero; the
    // read ports also force zero for index 0 independently of storage.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            regArray <= '0;
        end else if (bus.RegWrite && (bus.WriteRegister != REG_ZERO)) begin
            regArray[bus.WriteRegister] <= bus.WriteData;
        end
    end

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) readPort1 (
        .readAddr  (bus.ReadRegister1),
        .regArray  (regArray),
        .bypassEn  (writeEn),
        .writeAddr (bus.WriteRegister),
        .writeData (bus.WriteData),
        .readData  (bus.ReadData1)
    );

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) readPort2 (
        .readAddr  (bus.ReadRegister2),
        .regArray  (regArray),
        .bypassEn  (writeEn),
        .writeAddr (bus.WriteRegister),
        .writeData (bus.WriteData),
        .readData  (bus.ReadData2)
    );

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (both build flavours of REGFILE_BYPASS_EN).
// Inputs change 1 time unit after the rising edge; outputs are sampled between edges.
// Ends with a single summary line of errors and checks.
module tb_register_file;

    logic Clk;
    logic Reset;
    int   errCnt;
    int   checkCnt;

    register_file_if bus ();

    register_file dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checkCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Apply a single write on the next rising edge, then drop RegWrite.
    task automatic writeReg(input logic [4:0] addr, input logic [31:0] data);
        bus.RegWrite      = 1'b1;
        bus.WriteRegister = addr;
        bus.WriteData     = data;
        @(posedge Clk);
        #1;
        bus.RegWrite      = 1'b0;
    endtask

    task automatic readPair(input logic [4:0] a1, input logic [4:0] a2);
        bus.ReadRegister1 = a1;
        bus.ReadRegister2 = a2;
        #1;
    endtask

    initial begin
        errCnt   = 0;
        checkCnt = 0;
        Reset             = 1'b1;
        bus.RegWrite      = 1'b0;
        bus.WriteRegister = '0;
        bus.WriteData     = '0;
        bus.ReadRegister1 = 5'd5;
        bus.ReadRegister2 = 5'd6;

        // Reset state
        #2;
        checkVal("reset_rd1", bus.ReadData1, 32'd0);
        checkVal("reset_rd2", bus.ReadData2, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk);
        #1;

        // Basic write/read
        writeReg(5'd5, 32'd10);
        bus.RegWrite      = 1'b0;
        bus.WriteRegister = 5'd10;
        bus.WriteData     = 32'd10;
        @(posedge Clk);
        #1;
        readPair(5'd5, 5'd30);
        checkVal("basic_r5", bus.ReadData1, 32'd10);
        checkVal("basic_r30", bus.ReadData2, 32'd0);
        readPair(5'd10, 5'd5);
        checkVal("basic_r10_unwritten", bus.ReadData1, 32'd0);
        writeReg(5'd10, 32'd20);
        readPair(5'd10, 5'd5);
        checkVal("basic_r10", bus.ReadData1, 32'd20);
        checkVal("basic_r5_kept", bus.ReadData2, 32'd10);

        // Bulk write regs 8..25 with i*3+1, read back in pairs
        for (int i = 8; i <= 25; i++) begin
            writeReg(i[4:0], 32'(i * 3 + 1));
        end
        for (int i = 8; i <= 24; i += 2) begin
            readPair(i[4:0], 5'(i + 1));
            checkVal($sformatf("bulk_rd1_r%0d", i), bus.ReadData1, 32'(i * 3 + 1));
            checkVal($sformatf("bulk_rd2_r%0d", i + 1), bus.ReadData2, 32'((i + 1) * 3 + 1));
        end

        // Register 0 ignores writes, reads zero (also before the edge)
        readPair(5'd0, 5'd0);
        bus.RegWrite      = 1'b1;
        bus.WriteRegister = 5'd0;
        bus.WriteData     = 32'hFFFF_FFFF;
        #1;
        checkVal("r0_pre_rd1", bus.ReadData1, 32'd0);
        checkVal("r0_pre_rd2", bus.ReadData2, 32'd0);
        @(posedge Clk);
        #1;
        bus.RegWrite = 1'b0;
        #1;
        checkVal("r0_post_rd1", bus.ReadData1, 32'd0);
        checkVal("r0_post_rd2", bus.ReadData2, 32'd0);

        // Write enable low for three edges
        writeReg(5'd12, 32'd7);
        bus.RegWrite      = 1'b0;
        bus.WriteRegister = 5'd12;
        bus.WriteData     = 32'd99;
        repeat (3) @(posedge Clk);
        #1;
        readPair(5'd12, 5'd12);
        checkVal("we_low_rd1", bus.ReadData1, 32'd7);
        checkVal("we_low_rd2", bus.ReadData2, 32'd7);

        // Same-cycle read/write on reg 15
        writeReg(5'd15, 32'd4);
        readPair(5'd15, 5'd15);
        bus.RegWrite      = 1'b1;
        bus.WriteRegister = 5'd15;
        bus.WriteData     = 32'd9;
        #1;
`ifdef REGFILE_BYPASS_EN
        checkVal("same_pre_rd1", bus.ReadData1, 32'd9);
        checkVal("same_pre_rd2", bus.ReadData2, 32'd9);
`else
        checkVal("same_pre_rd1", bus.ReadData1, 32'd4);
        checkVal("same_pre_rd2", bus.ReadData2, 32'd4);
`endif
        @(posedge Clk);
        #1;
        bus.RegWrite = 1'b0;
        #1;
        checkVal("same_post_rd1", bus.ReadData1, 32'd9);
        checkVal("same_post_rd2", bus.ReadData2, 32'd9);

        // Asynchronous reset mid-operation
        writeReg(5'd8, 32'h1234);
        readPair(5'd8, 5'd9);
        checkVal("rst_pre_r8", bus.ReadData1, 32'h1234);
        checkVal("rst_pre_r9", bus.ReadData2, 32'd28);
        Reset = 1'b1;
        #1;
        checkVal("rst_async_r8", bus.ReadData1, 32'd0);
        checkVal("rst_async_r9", bus.ReadData2, 32'd0);
        // A write attempted during reset must be blocked (and not forwarded).
        bus.RegWrite      = 1'b1;
        bus.WriteRegister = 5'd9;
        bus.WriteData     = 32'd55;
        #1;
        checkVal("rst_no_bypass", bus.ReadData2, 32'd0);
        @(posedge Clk);
        #1;
        bus.RegWrite = 1'b0;
        Reset        = 1'b0;
        @(posedge Clk);
        #1;
        checkVal("rst_after_r8", bus.ReadData1, 32'd0);
        checkVal("rst_after_r9", bus.ReadData2, 32'd0);
        readPair(5'd5, 5'd10);
        checkVal("rst_after_r5", bus.ReadData1, 32'd0);
        checkVal("rst_after_r10", bus.ReadData2, 32'd0);

        // Normal writes resume after reset
        writeReg(5'd20, 32'hCAFE_F00D);
        readPair(5'd20, 5'd0);
        checkVal("post_rst_write_r20", bus.ReadData1, 32'hCAFE_F00D);
        checkVal("post_rst_r0", bus.ReadData2, 32'd0);

        $display("Result: errors=%0d of %0d checks", errCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry by 32-bit general-purpose register file for the MIPS-style datapath, sitting in the decode stage.
- Two asynchronous (combinational) read ports and one synchronous write port.
- Register 0 is hardwired to zero.
- Asynchronous active-high reset clears all registers.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, width of the register index ports.
- NUM_REGS, 32, number of registers; must equal 2**ADDR_WIDTH.

Ports:
- Clk  input  1  clock; writes occur on its rising edge.
- Reset  input  1  asynchronous, active-high reset; clears every register to 0.
- ReadRegister1  input  ADDR_WIDTH  index for read port 1.
- ReadRegister2  input  ADDR_WIDTH  index for read port 2.
- WriteRegister  input  ADDR_WIDTH  index for the write port.
- WriteData  input  DATA_WIDTH  data to write.
- RegWrite  input  1  write enable, sampled at the rising edge of Clk.
- ReadData1  output  DATA_WIDTH  contents of register ReadRegister1.
- ReadData2  output  DATA_WIDTH  contents of register ReadRegister2.

Behaviour:
- Storage: NUM_REGS registers of DATA_WIDTH bits.
- Reset:
  - While Reset=1, all registers are 0 immediately, without waiting for a clock edge.
  - Consequently ReadData1 = ReadData2 = 0 during reset.
  - Writes are blocked while Reset=1.
  - Deassertion takes effect at the next rising edge.
- Write:
  - At a rising edge of Clk with Reset=0 and RegWrite=1, reg[WriteRegister] <= WriteData.
  - With RegWrite=0, no register changes.
  - Write latency is one edge: the new value appears on the read ports right after that edge.
- Register 0:
  - Writes to index 0 are ignored.
  - Reads of index 0 always return 0.
- Read:
  - Purely combinational, with no clock involvement.
  - ReadDataN = reg[ReadRegisterN], or 0 when ReadRegisterN = 0.
  - Output follows any change of the address or of the stored value in the same delta.
- Both read ports may address the same register; each returns the same value.
- Same-cycle read of the register being written (feature disabled):
  - Before the edge, the read port returns the old value.
  - After the edge, it returns the new value.
- Multiple writes to one register: the last edge wins.
- X/Z handling: none required; behaviour for unknown addresses is unspecified.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- When defined, write-through forwarding is enabled:
  - If RegWrite=1, Reset=0, WriteRegister≠0 and ReadRegisterN == WriteRegister, then ReadDataN = WriteData combinationally.
  - This holds before the clock edge, so a value written in the same cycle can be read in that cycle.
- When undefined, reads always return stored contents only, as described in Behaviour.
- Register 0 remains zero in both modes.

Decomposition:
- Shared package regfile_pkg:
  - DATA_WIDTH and ADDR_WIDTH constants.
  - Typedefs reg_data_t (logic [DATA_WIDTH-1:0]) and reg_addr_t (logic [ADDR_WIDTH-1:0]).
  - Constant REG_ZERO = 0.
- One natural sub-module: regfile_read_port.
  - Combinational zero-check, optional bypass compare and array select.
  - Instantiated twice, once per read port.
- The storage array and write logic live in register_file.

Test Plan:
- Reset: assert Reset mid-operation after writing 0x1234 to reg 8 → ReadData1 (reg 8) = 0 immediately, without a clock edge; after deassertion, reg 8 still reads 0.
- Basic write/read: RegWrite=1, WriteRegister=5, WriteData=10 at edge 1; then RegWrite=0, WriteRegister=10, WriteData=10 at edge 2 → ReadData1(reg 5)=10, ReadData2(reg 30)=0, reg 10 still 0. Then RegWrite=1, WriteRegister=10, WriteData=20 → after the edge, ReadData1(reg 10)=20 and reg 5 is still 10.
- Bulk write: write value i*3+1 to regs 8–25 on consecutive edges; then read two at a time (8/9, 10/11, …, 24/25) → each port returns its written value, with no cross-talk.
- Register 0: RegWrite=1, WriteRegister=0, WriteData=0xFFFFFFFF → ReadData1(reg 0)=0 and ReadData2(reg 0)=0.
- Write enable low: reg 12 holds 7; apply RegWrite=0, WriteRegister=12, WriteData=99 for 3 edges → reg 12 still reads 7.
- Same-cycle read/write on reg 15 (old 4, new 9), both ports addressing 15:
  - Without REGFILE_BYPASS_EN: reads 4 before the edge and 9 after.
  - With REGFILE_BYPASS_EN: reads 9 before the edge.
